cla_addsub_pipe: RTL



---
 rtl/cla_pkg.sv | 26 ++
 rtl/cla_block.sv | 53 +++++
 rtl/cla_addsub_pipe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants, stage-register layout and depth helper for the
// pipelined carry-lookahead adder/subtractor (cla_addsub_pipe).
package cla_pkg;

    // Default operand width and slice width for the adder pipeline.
    localparam int CLA_WIDTH = 16;
    localparam int CLA_BLK   = 4;

    // Layout of one pipeline stage register at the default width:
    // beat valid, raw operands, partial sum built so far, the carry
    // leaving the slice just resolved, and the operation mode.
    typedef struct packed {
        logic                 valid;
        logic [CLA_WIDTH-1:0] a;
        logic [CLA_WIDTH-1:0] b;
        logic [CLA_WIDTH-1:0] sum;
        logic                 carry;
        logic                 sub;
    } cla_stage_t;

    // Number of slices, which is also the pipeline depth.
    function automatic int cla_nblk(input int width, input int blk);
        return width / blk;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLK-bit carry-lookahead slice. Every internal carry is
// formed directly from generate/propagate terms and the slice carry-in,
// so no carry ripples through the slice. The carry into the slice MSB
// is exported so the caller can form signed overflow.
module cla_block
    import cla_pkg::*;
#(
    parameter int BLK = CLA_BLK
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           c_msb_in
);

    logic [BLK-1:0] w_gen;
    logic [BLK-1:0] w_prop;
    logic [BLK:0]   w_carry;

    assign w_gen  = a & b;
    assign w_prop = a ^ b;

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin,
    // each product term built explicitly rather than chained.
    always_comb begin
        logic w_chain;
        logic w_acc;
        w_carry    = '0;
        w_carry[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            w_chain = cin;
            for (int k = 0; k <= i; k++) begin
                w_chain = w_chain & w_prop[k];
            end
            w_acc = w_chain;
            for (int k = 0; k <= i; k++) begin
                w_chain = w_gen[k];
                for (int m = k + 1; m <= i; m++) begin
                    w_chain = w_chain & w_prop[m];
                end
                w_acc = w_acc | w_chain;
            end
            w_carry[i+1] = w_acc;
        end
    end

    assign s        = w_prop ^ w_carry[BLK-1:0];
    assign cout     = w_carry[BLK];
    assign c_msb_in = w_carry[BLK-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor. One BLK-bit slice is
// resolved per stage with the carry registered between stages, giving a
// depth of WIDTH/BLK. Valid/ready handshake: the whole pipeline freezes
// while the result is valid and not accepted. Flags (carry, signed
// overflow, zero) are formed as the last slice is resolved and held in
// output registers together with the sum.
// Optional build macro CLA_ADDSUB_SATURATE_EN: clamp the sum to the
// signed extreme on overflow instead of wrapping.
// WIDTH must be a multiple of BLK and at least BLK.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int BLK   = CLA_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NBLK = cla_nblk(WIDTH, BLK);

    // Same field layout as cla_stage_t, sized by this instance's WIDTH.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             sub;
    } stage_t;

    stage_t           r_stage [NBLK];
    stage_t           w_next  [NBLK];

    logic             w_stValid [NBLK];
    logic [WIDTH-1:0] w_stA     [NBLK];
    logic [WIDTH-1:0] w_stB     [NBLK];
    logic [WIDTH-1:0] w_stSum   [NBLK];
    logic             w_stSub   [NBLK];
    logic             w_stCin   [NBLK];

    logic [BLK-1:0]   w_blkB    [NBLK];
    logic [BLK-1:0]   w_blkS    [NBLK];
    logic             w_blkCout [NBLK];
    logic             w_blkCmsb [NBLK];

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_stall;
    logic             w_finalOvf;
    logic [WIDTH-1:0] w_finalSum;
    logic             w_finalZero;

    assign w_stall   = r_stage[NBLK-1].valid && !out_ready;
    assign in_ready  = !w_stall;
    assign out_valid = r_stage[NBLK-1].valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

    // Select what each stage works on: stage 0 takes the ports (with the
    // borrow-in inverted for subtract), later stages take the register
    // of the stage before them.
    always_comb begin
        w_stValid[0] = in_valid;
        w_stA[0]     = a;
        w_stB[0]     = b;
        w_stSub[0]   = sub;
        w_stCin[0]   = sub ? ~cin : cin;
        w_stSum[0]   = '0;
        for (int j = 1; j < NBLK; j++) begin
            w_stValid[j] = r_stage[j-1].valid;
            w_stA[j]     = r_stage[j-1].a;
            w_stB[j]     = r_stage[j-1].b;
            w_stSub[j]   = r_stage[j-1].sub;
            w_stCin[j]   = r_stage[j-1].carry;
            w_stSum[j]   = r_stage[j-1].sum;
        end
    end

    for (genvar j = 0; j < NBLK; j++) begin : g_stage
        assign w_blkB[j] = w_stSub[j] ? ~w_stB[j][j*BLK +: BLK]
                                      :  w_stB[j][j*BLK +: BLK];

        cla_block #(.BLK(BLK)) u_block (
            .a        (w_stA[j][j*BLK +: BLK]),
            .b        (w_blkB[j]),
            .cin      (w_stCin[j]),
            .s        (w_blkS[j]),
            .cout     (w_blkCout[j]),
            .c_msb_in (w_blkCmsb[j])
        );
    end

    // Next contents of each stage register: operands pass through, the
    // slice just resolved is merged into the partial sum, and its carry
    // is handed on to the next stage.
    always_comb begin
        for (int j = 0; j < NBLK; j++) begin
            w_next[j].valid = w_stValid[j];
            w_next[j].a     = w_stA[j];
            w_next[j].b     = w_stB[j];
            w_next[j].sub   = w_stSub[j];
            w_next[j].carry = w_blkCout[j];
            w_next[j].sum   = w_stSum[j];
            w_next[j].sum[j*BLK +: BLK] = w_blkS[j];
        end
    end

    assign w_finalOvf = w_blkCmsb[NBLK-1] ^ w_blkCout[NBLK-1];

    // Final-stage result; on overflow the true result has the sign of
    // operand A, which picks the extreme to clamp to when saturating.
    always_comb begin
        w_finalSum = w_next[NBLK-1].sum;
`ifdef CLA_ADDSUB_SATURATE_EN
        if (w_finalOvf) begin
            w_finalSum = w_stA[NBLK-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    assign w_finalZero = (w_finalSum == '0);

    // Stage registers advance together unless the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NBLK; j++) begin
                r_stage[j] <= '0;
            end
        end else if (!w_stall) begin
            for (int j = 0; j < NBLK; j++) begin
                r_stage[j] <= w_next[j];
            end
        end
    end

    // Result and flags load only with a valid beat, so they hold their
    // last values across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (!w_stall && w_next[NBLK-1].valid) begin
            r_sum  <= w_finalSum;
            r_cout <= w_next[NBLK-1].carry;
            r_ovf  <= w_finalOvf;
            r_zero <= w_finalZero;
        end
    end

endmodule
